// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family: fill direction and
// universal register mode encodings, so loopback benches can translate a
// transmitter mode into the receiver's msb_first setting.
package shift_pkg;

  // Fill direction of the receive collect register
  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  // Universal shift register mode encodings
  typedef enum logic [1:0] {
    MODE_HOLD        = 2'b00,
    MODE_SHIFT_RIGHT = 2'b01,
    MODE_SHIFT_LEFT  = 2'b10,
    MODE_LOAD        = 2'b11
  } shift_mode_e;

  // A shift-left transmitter emits its MSB first; everything else is
  // treated as LSB-first on the wire.
  function automatic logic mode_to_dir(input shift_mode_e mode);
    return (mode == MODE_SHIFT_LEFT) ? DIR_MSB_FIRST : DIR_LSB_FIRST;
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Bundle of serial input, parallel valid/ready output and status signals
// for the serial deserializer. The master side drives serial bits and
// out_ready; the slave side is the receiver.
interface serial_deserializer_if #(
  parameter int N = 4
);
  localparam int CW = $clog2(N);

  logic          serial_in;
  logic          serial_valid;
  logic          msb_first;
  logic          frame_sync;
  logic          clr_overflow;
  logic [N-1:0]  parallel_out;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
  logic [CW-1:0] bit_count;

  modport master (
    output serial_in,
    output serial_valid,
    output msb_first,
    output frame_sync,
    output clr_overflow,
    output out_ready,
    input  parallel_out,
    input  out_valid,
    input  overflow,
    input  bit_count
  );

  modport slave (
    input  serial_in,
    input  serial_valid,
    input  msb_first,
    input  frame_sync,
    input  clr_overflow,
    input  out_ready,
    output parallel_out,
    output out_valid,
    output overflow,
    output bit_count
  );

endinterface

// File: rtl/serial_deserializer_out_buf.sv
// deser_out_buf: single-entry holding register with valid/ready output.
// A load is taken whenever the entry is free, including the cycle in which
// the current word is being popped; otherwise the load is reported as a drop
// and the held word is left untouched.
module deser_out_buf #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         ready,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         drop
);

  logic free;

  // Entry is free when empty or being consumed on this edge
  always_comb begin
    free = !valid || ready;
    drop = load && !free;
  end

  // Holding register: load has priority over a plain pop; data persists after a pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load && free) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: collects N serial bits into a word (MSB- or LSB-first
// fill, direction latched on bit 0 of each word) and hands completed words to
// a double-buffering holding register with a valid/ready output. A word that
// completes while the holding register is still occupied is dropped and
// flagged on the sticky overflow output.
module serial_deserializer
  import shift_pkg::*;
#(
  parameter int N = 4
) (
  input logic                 clk,
  input logic                 reset,
  serial_deserializer_if.slave bus
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  logic [N-1:0]  collect_q;
  logic [CW-1:0] bit_count_q;
  logic          dir_q;
  logic          overflow_q;

  logic [N-1:0]  eff_collect;
  logic [CW-1:0] eff_count;
  logic          eff_dir;
  logic [N-1:0]  next_word;
  logic          word_done;
  logic          word_drop;

  // frame_sync restarts the word before this cycle's bit is considered, so the
  // bit arriving with it becomes bit 0 and latches a fresh direction.
  always_comb begin
    eff_count   = bus.frame_sync ? '0 : bit_count_q;
    eff_collect = bus.frame_sync ? '0 : collect_q;
    eff_dir     = (eff_count == '0) ? bus.msb_first : dir_q;
    if (eff_dir == DIR_MSB_FIRST) begin
      next_word = {eff_collect[N-2:0], bus.serial_in};
    end else begin
      next_word = {bus.serial_in, eff_collect[N-1:1]};
    end
    word_done = bus.serial_valid && (eff_count == LAST_BIT);
  end

  // Collect register, bit counter and latched direction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collect_q   <= '0;
      bit_count_q <= '0;
      dir_q       <= DIR_LSB_FIRST;
    end else if (bus.serial_valid) begin
      if (eff_count == '0) begin
        dir_q <= bus.msb_first;
      end
      if (word_done) begin
        collect_q   <= '0;
        bit_count_q <= '0;
      end else begin
        collect_q   <= next_word;
        bit_count_q <= eff_count + CW'(1);
      end
    end else if (bus.frame_sync) begin
      collect_q   <= '0;
      bit_count_q <= '0;
    end
  end

  deser_out_buf #(
    .N(N)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (word_done),
    .load_data (next_word),
    .ready     (bus.out_ready),
    .data      (bus.parallel_out),
    .valid     (bus.out_valid),
    .drop      (word_drop)
  );

  // Sticky overflow; a drop on the same edge as a clear keeps it set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (word_drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.bit_count = bit_count_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer (N=4): stimulus pushes expected
// words as they are sent; a negedge monitor pops and compares every word the
// DUT hands over on its valid/ready output.
module tb_serial_deserializer;
  import shift_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_deserializer_if #(.N(N)) bus ();

  serial_deserializer #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic b);
    bus.serial_valid = 1'b1;
    bus.serial_in    = b;
    tick();
    bus.serial_valid = 1'b0;
    bus.serial_in    = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic msb, input logic kept);
    bus.msb_first = msb;
    if (kept) exp_q.push_back(w);
    for (int i = 0; i < N; i++) put_bit(msb ? w[N-1-i] : w[i]);
  endtask

  // Monitor: a word is consumed on the coming edge when valid and ready are both high
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", bus.parallel_out);
      end else begin
        check("word", {28'd0, bus.parallel_out}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.serial_in    = 1'b0;
    bus.serial_valid = 1'b0;
    bus.msb_first    = DIR_LSB_FIRST;
    bus.frame_sync   = 1'b0;
    bus.clr_overflow = 1'b0;
    bus.out_ready    = 1'b0;
    #7;
    check("rst_pout", {28'd0, bus.parallel_out}, 32'h0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'h0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'h0);
    check("rst_cnt", {30'd0, bus.bit_count}, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // MSB-first word, consumed the cycle after it appears
    bus.out_ready = 1'b1;
    send_word(4'b1011, DIR_MSB_FIRST, 1'b1);
    check("t1_valid", {31'd0, bus.out_valid}, 32'h1);
    check("t1_pout", {28'd0, bus.parallel_out}, 32'hB);
    check("t1_cnt", {30'd0, bus.bit_count}, 32'h0);
    tick();
    check("t1_valid_fall", {31'd0, bus.out_valid}, 32'h0);
    check("t1_pout_hold", {28'd0, bus.parallel_out}, 32'hB);

    // LSB-first with the same wire bits 1,0,1,1
    send_word(4'b1101, DIR_LSB_FIRST, 1'b1);
    check("t2_pout", {28'd0, bus.parallel_out}, 32'hD);
    tick();

    // Direction toggled after bit 0 is ignored
    exp_q.push_back(4'b1101);
    bus.msb_first = DIR_LSB_FIRST;
    put_bit(1'b1);
    bus.msb_first = DIR_MSB_FIRST;
    put_bit(1'b0);
    check("t2_cnt_mid", {30'd0, bus.bit_count}, 32'h2);
    put_bit(1'b1);
    put_bit(1'b1);
    check("t2_latched", {28'd0, bus.parallel_out}, 32'hD);
    tick();

    // Overflow: second word dropped while the first is held
    bus.out_ready = 1'b0;
    send_word(4'b1010, DIR_MSB_FIRST, 1'b1);
    send_word(4'b0110, DIR_MSB_FIRST, 1'b0);
    check("t3_pout", {28'd0, bus.parallel_out}, 32'hA);
    check("t3_valid", {31'd0, bus.out_valid}, 32'h1);
    check("t3_ovf", {31'd0, bus.overflow}, 32'h1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("t3_clr", {31'd0, bus.overflow}, 32'h0);

    // Clear coinciding with a new drop: set wins
    bus.msb_first = DIR_MSB_FIRST;
    put_bit(1'b1);
    put_bit(1'b1);
    put_bit(1'b1);
    bus.clr_overflow = 1'b1;
    put_bit(1'b1);
    bus.clr_overflow = 1'b0;
    check("t3_set_wins", {31'd0, bus.overflow}, 32'h1);
    check("t3_pout_kept", {28'd0, bus.parallel_out}, 32'hA);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("t3_clr2", {31'd0, bus.overflow}, 32'h0);

    // Pop and load on the same edge
    exp_q.push_back(4'b0011);
    put_bit(1'b0);
    put_bit(1'b0);
    put_bit(1'b1);
    bus.out_ready = 1'b1;
    put_bit(1'b1);
    bus.out_ready = 1'b0;
    check("t4_pout", {28'd0, bus.parallel_out}, 32'h3);
    check("t4_valid", {31'd0, bus.out_valid}, 32'h1);
    check("t4_ovf", {31'd0, bus.overflow}, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    check("t4_drained", {31'd0, bus.out_valid}, 32'h0);

    // frame_sync with a bit restarts the word at that bit
    exp_q.push_back(4'b1001);
    bus.msb_first = DIR_MSB_FIRST;
    put_bit(1'b1);
    put_bit(1'b1);
    check("t5_cnt_partial", {30'd0, bus.bit_count}, 32'h2);
    bus.frame_sync = 1'b1;
    put_bit(1'b1);
    bus.frame_sync = 1'b0;
    check("t5_cnt_sync", {30'd0, bus.bit_count}, 32'h1);
    put_bit(1'b0);
    put_bit(1'b0);
    put_bit(1'b1);
    check("t5_pout", {28'd0, bus.parallel_out}, 32'h9);
    tick();

    // frame_sync alone discards a partial word
    put_bit(1'b1);
    bus.frame_sync = 1'b1;
    tick();
    bus.frame_sync = 1'b0;
    check("t5_sync_only", {30'd0, bus.bit_count}, 32'h0);
    send_word(4'b0110, DIR_MSB_FIRST, 1'b1);
    check("t5_after_sync", {28'd0, bus.parallel_out}, 32'h6);

    // Back-to-back words at full rate
    send_word(4'b1110, DIR_MSB_FIRST, 1'b1);
    send_word(4'b0001, DIR_MSB_FIRST, 1'b1);
    check("tp_pout", {28'd0, bus.parallel_out}, 32'h1);
    tick();

    // Async reset mid-word with a held word and overflow set
    bus.out_ready = 1'b0;
    send_word(4'b1100, DIR_MSB_FIRST, 1'b0);
    send_word(4'b0000, DIR_MSB_FIRST, 1'b0);
    put_bit(1'b1);
    put_bit(1'b1);
    put_bit(1'b1);
    check("t6_cnt", {30'd0, bus.bit_count}, 32'h3);
    check("t6_ovf_pre", {31'd0, bus.overflow}, 32'h1);
    #3;
    reset = 1'b0;
    #1;
    check("t6_pout", {28'd0, bus.parallel_out}, 32'h0);
    check("t6_valid", {31'd0, bus.out_valid}, 32'h0);
    check("t6_cnt_rst", {30'd0, bus.bit_count}, 32'h0);
    check("t6_ovf", {31'd0, bus.overflow}, 32'h0);
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    send_word(4'b0101, DIR_MSB_FIRST, 1'b1);
    check("t6_clean", {28'd0, bus.parallel_out}, 32'h5);
    tick();
    tick();

    check("queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-in, parallel-out receiver: the far end of a serial link driven by a universal shift register in shift-left or shift-right mode. It collects N serial bits into a word and presents the word on a valid/ready parallel output. A holding register double-buffers the output so reception continues while a word waits. Placed in the Shift Registers group as the receive side for serial loopback tests.

## Interface
- N, 4, word width in bits (N ≥ 2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- serial_in  in  1  serial data bit
- serial_valid  in  1  serial_in is a real bit this cycle
- msb_first  in  1  1: first bit received lands in bit N-1 (shift-left fill); 0: first bit lands in bit 0 (shift-right fill)
- frame_sync  in  1  discard any partial word and restart at bit 0
- clr_overflow  in  1  synchronous clear of overflow
- parallel_out  out  N  completed word (holding register)
- out_valid  out  1  parallel_out holds an unconsumed word
- out_ready  in  1  consumer accepts parallel_out this cycle
- overflow  out  1  sticky: a completed word was dropped
- bit_count  out  $clog2(N)  bits collected in the current partial word

## Operation
- Reset (reset=0, async): shift register, parallel_out, bit_count = 0; out_valid = 0; overflow = 0; latched direction = 0.
- Bit accept: serial_valid=1 on an edge. serial_in enters the collect register, and bit_count increments.
- msb_first is latched when bit 0 of a word is accepted. Changes mid-word are ignored until the next word.
- Fill for msb_first=1: shift left, serial_in enters bit 0. After N bits the first bit is in bit N-1.
- Fill for msb_first=0: shift right, serial_in enters bit N-1. After N bits the first bit is in bit 0.
- Word complete: the accepted bit is the Nth (bit_count = N-1 before the edge).
  - Assembled word (including this bit) goes to the holding register.
  - bit_count wraps to 0; collect register clears.
- Holding register is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle. A pop and a load on one edge both succeed.
- Holding register not free at word complete: word is dropped, parallel_out is unchanged, overflow is set.
- Output handshake: word is consumed on an edge with out_valid=1 and out_ready=1. out_valid then falls unless a new word loads on the same edge. parallel_out holds its value after consumption.
- frame_sync=1: bit_count and collect register clear.
  - If serial_valid is also 1, that bit is accepted as bit 0 of the new word, and msb_first is latched.
  - frame_sync does not affect the holding register or overflow.
- overflow stays set until reset or clr_overflow. If clr_overflow coincides with a new drop, overflow stays 1 (set wins).
- serial_valid=0: no state change except the output handshake.

## Timing
- Latency: the Nth bit accepted at edge k makes out_valid=1 and parallel_out valid after edge k. That is N edges from the first bit when serial_valid is continuous.
- Sustained throughput: one word per N cycles with out_ready tied high. No bubbles are required between words.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset deasserts synchronously to clk externally. Reset asserted mid-word drops the partial word and any held word.

## Structure
- Shared package shift_pkg holds:
  - direction constants DIR_LSB_FIRST=1'b0 and DIR_MSB_FIRST=1'b1;
  - the universal register mode encodings (hold 2'b00, shift right 2'b01, shift left 2'b10, load 2'b11), so loopback benches map modes to msb_first.
- Sub-module deser_out_buf: N-bit holding register with valid/ready and a drop indication.
- Collect and count logic stays in the top module.

## Test plan
- N=4, msb_first=1, serial bits 1,0,1,1 on four consecutive edges, out_ready=1 -> parallel_out=4'b1011 and out_valid=1 after the 4th edge, for one cycle; bit_count=0.
- Same bits with msb_first=0 -> parallel_out=4'b1101. Toggle msb_first after bit 1 -> result unchanged (latched direction).
- out_ready=0; send 4'b1010 then 4'b0110 (msb_first=1) -> parallel_out stays 4'b1010 and overflow=1. clr_overflow -> overflow=0.
- Word 1 held (out_valid=1), out_ready=1 on the same edge the 2nd word completes -> parallel_out = 2nd word, out_valid stays 1, overflow=0.
- Two bits accepted, then frame_sync with serial_valid=1 and serial_in=1, then bits 0,0,1 (msb_first=1) -> word 4'b1001; the partial bits are discarded.
- Reset pulsed low asynchronously mid-clock after 3 bits with a word held -> outputs immediately 0, out_valid=0; next 4 bits form a clean word.
